// File: rtl/game_flow_ctrl_if.sv
// Board-side bundle of the game-flow sequencer: switch/button/mic inputs and screen/record outputs.
// Latency: none, wires only.
// Backpressure: none; every output is a level, play_start is a single-cycle pulse.
//   master: board I/O side (drives en, buttons, volume, rd_addr; observes the outputs)
//   slave : game_flow_ctrl side
interface game_flow_ctrl_if #(
    parameter int VOL_W = 5,
    parameter int AW    = 4
);
    logic             en;
    logic             btn_l;
    logic             btn_r;
    logic             btn_c;
    logic [VOL_W-1:0] volume;
    logic [AW-1:0]    rd_addr;
    logic [3:0]       state;
    logic [3:0]       count;
    logic [AW:0]      rec_len;
    logic [VOL_W-1:0] rec_peak;
    logic [VOL_W-1:0] rd_data;
    logic             play_start;

    modport master (
        output en, btn_l, btn_r, btn_c, volume, rd_addr,
        input  state, count, rec_len, rec_peak, rd_data, play_start
    );

    modport slave (
        input  en, btn_l, btn_r, btn_c, volume, rd_addr,
        output state, count, rec_len, rec_peak, rd_data, play_start
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: walks title..play screens, records mic volume into a circular buffer, runs start countdown.
// Latency: buttons reach the state 3 clk after a raw edge (2-flop sync + edge detect); rd_data 1 clk after rd_addr.
// Backpressure: none; a held button produces one pulse, en low forces IDLE on the next clk.
//   Ports: clk, rst_n (async active-low); io (game_flow_ctrl_if.slave):
//     en/btn_l/btn_r/btn_c/volume/rd_addr in; state/count/rec_len/rec_peak/rd_data/play_start out.
//   Optional feature macro GAME_FLOW_SKIP_EN: left button on the title screen jumps straight to RECORD_START.
module game_flow_ctrl #(
    parameter int VOL_W      = 5,
    parameter int REC_DEPTH  = 16,
    parameter int SAMPLE_DIV = 50000000,
    parameter int SEC_DIV    = 100000000,
    parameter int COUNTDOWN  = 5,
    parameter int VOL_MIN    = 3
) (
    input logic            clk,
    input logic            rst_n,
    game_flow_ctrl_if.slave io
);
    localparam int AW  = $clog2(REC_DEPTH);
    localparam int SDW = $clog2(SAMPLE_DIV);
    localparam int CDW = $clog2(SEC_DIV);

    localparam logic [VOL_W-1:0] VMIN      = VOL_W'(VOL_MIN);
    localparam logic [3:0]       CD_INIT   = 4'(COUNTDOWN);
    localparam logic [AW:0]      LEN_MAX   = (AW+1)'(REC_DEPTH);
    localparam logic [SDW-1:0]   SDIV_LAST = SDW'(SAMPLE_DIV - 1);
    localparam logic [CDW-1:0]   CDIV_LAST = CDW'(SEC_DIV - 1);

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        TITLE        = 4'd1,
        CONTROLS_1   = 4'd2,
        CONTROLS_2   = 4'd3,
        SETTINGS     = 4'd4,
        MIC_START    = 4'd5,
        MIC_VOLUME   = 4'd6,
        RECORD_START = 4'd7,
        RECORD_SPEAK = 4'd8,
        GAME_START   = 4'd10,
        GAME_PLAY    = 4'd11
    } state_t;

    state_t           state, nxt;
    logic [3:0]       count;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      rec_len;
    logic [VOL_W-1:0] rec_peak;
    logic [VOL_W-1:0] rd_data;
    logic             play_start;
    logic [VOL_W-1:0] mem [REC_DEPTH];

    // Button synchronisers; prev_* holds the synchronised level one clk older for edge detection.
    // The centre button is only ever used as a level.
    logic [1:0] sync_l, sync_r, sync_c;
    logic       prev_l, prev_r;
    logic       pulse_l, pulse_r, btn_c_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_l <= '0;
            sync_r <= '0;
            sync_c <= '0;
            prev_l <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            sync_l <= {sync_l[0], io.btn_l};
            sync_r <= {sync_r[0], io.btn_r};
            sync_c <= {sync_c[0], io.btn_c};
            prev_l <= sync_l[1];
            prev_r <= sync_r[1];
        end
    end

    assign pulse_l   = sync_l[1] & ~prev_l;
    assign pulse_r   = sync_r[1] & ~prev_r;
    assign btn_c_lvl = sync_c[1];

    // Tick dividers only run in their owning state, so the first tick lands a full period after entry.
    logic [SDW-1:0] sdiv;
    logic [CDW-1:0] cdiv;
    logic           sample_tick, sec_tick;

    assign sample_tick = (state == RECORD_SPEAK) && (sdiv == SDIV_LAST);
    assign sec_tick    = (state == GAME_START)   && (cdiv == CDIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdiv <= '0;
            cdiv <= '0;
        end else begin
            sdiv <= (state != RECORD_SPEAK || sample_tick) ? '0 : sdiv + 1'b1;
            cdiv <= (state != GAME_START   || sec_tick)    ? '0 : cdiv + 1'b1;
        end
    end

    // Peak including a sample taken this very clk, so a release coinciding with a tick is judged on it.
    logic [VOL_W-1:0] peak_next;
    assign peak_next = (sample_tick && io.volume > rec_peak) ? io.volume : rec_peak;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:         nxt = TITLE;
            TITLE: begin
                if (pulse_r)      nxt = CONTROLS_1;
`ifdef GAME_FLOW_SKIP_EN
                else if (pulse_l) nxt = RECORD_START;
`endif
            end
            CONTROLS_1:   if (pulse_r) nxt = CONTROLS_2;
            CONTROLS_2:   if (pulse_r) nxt = SETTINGS;
            SETTINGS:     if (pulse_l || pulse_r) nxt = MIC_START;
            MIC_START:    if (pulse_r) nxt = MIC_VOLUME;
            MIC_VOLUME:   if (pulse_r) nxt = RECORD_START;
            RECORD_START: if (btn_c_lvl) nxt = RECORD_SPEAK;
            RECORD_SPEAK: if (!btn_c_lvl) nxt = (peak_next >= VMIN) ? GAME_START : RECORD_START;
            GAME_START:   if (sec_tick && count == 4'd0) nxt = GAME_PLAY;
            GAME_PLAY:    nxt = GAME_PLAY;
            default:      nxt = IDLE;
        endcase
        if (!io.en) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rec_len    <= '0;
            rec_peak   <= '0;
            rd_data    <= '0;
            play_start <= 1'b0;
        end else begin
            state      <= nxt;
            play_start <= (nxt == GAME_PLAY) && (state != GAME_PLAY);

            // Entering RECORD_START wins over a coincident tick: a failed take is discarded whole.
            if (nxt == RECORD_START && state != RECORD_START) begin
                wr_ptr   <= '0;
                rec_len  <= '0;
                rec_peak <= '0;
            end else if (sample_tick) begin
                wr_ptr   <= wr_ptr + 1'b1;
                rec_len  <= (rec_len == LEN_MAX) ? rec_len : rec_len + 1'b1;
                rec_peak <= peak_next;
            end

            if (nxt == GAME_START && state != GAME_START)
                count <= CD_INIT;
            else if (sec_tick && count != 4'd0)
                count <= count - 1'b1;

            // Index 0 is the newest sample, i.e. the slot just behind the write pointer.
            if ({1'b0, io.rd_addr} < rec_len)
                rd_data <= mem[wr_ptr - AW'(1) - io.rd_addr];
            else
                rd_data <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (sample_tick) mem[wr_ptr] <= io.volume;
    end

    assign io.state      = state;
    assign io.count      = count;
    assign io.rec_len    = rec_len;
    assign io.rec_peak   = rec_peak;
    assign io.rd_data    = rd_data;
    assign io.play_start = play_start;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: two instances (16-deep and 4-deep buffer) share one stimulus stream.
// A reference model of the screen flow, tick timing and newest-first sample list is compared every clk.
module tb_game_flow_ctrl;
    localparam int SD   = 4;
    localparam int SECD = 8;
    localparam int CD   = 5;
    localparam int VMIN = 3;
    localparam int DEP0 = 16;
    localparam int DEP1 = 4;
`ifdef GAME_FLOW_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
    logic [4:0] volume = '0;
    logic [3:0] rd_addr = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_flow_ctrl_if #(.VOL_W(5), .AW(4)) if0 ();
    game_flow_ctrl_if #(.VOL_W(5), .AW(2)) if1 ();

    assign if0.en = en;   assign if0.btn_l = btn_l; assign if0.btn_r = btn_r;
    assign if0.btn_c = btn_c; assign if0.volume = volume; assign if0.rd_addr = rd_addr;
    assign if1.en = en;   assign if1.btn_l = btn_l; assign if1.btn_r = btn_r;
    assign if1.btn_c = btn_c; assign if1.volume = volume; assign if1.rd_addr = rd_addr[1:0];

    game_flow_ctrl #(.VOL_W(5), .REC_DEPTH(DEP0), .SAMPLE_DIV(SD), .SEC_DIV(SECD),
                     .COUNTDOWN(CD), .VOL_MIN(VMIN))
        dut0 (.clk(clk), .rst_n(rst_n), .io(if0));
    game_flow_ctrl #(.VOL_W(5), .REC_DEPTH(DEP1), .SAMPLE_DIV(SD), .SEC_DIV(SECD),
                     .COUNTDOWN(CD), .VOL_MIN(VMIN))
        dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw button history: bit0 = level seen at the last edge, bit1 = two edges ago, bit2 = three.
    bit [2:0] hl, hr;
    bit [1:0] hc;
    int m_state, m_age, m_count, m_peak;
    bit m_play;
    int m_len [2];
    int m_rd  [2];
    int mlist [2][16];   // newest sample first

    task automatic model_step();
        int  ns, vol, a1;
        bit  pl, pr, lc, stick, ctick;
        int  npeak;
        pl    = hl[1] && !hl[2];
        pr    = hr[1] && !hr[2];
        lc    = hc[1];
        vol   = int'(volume);
        stick = (m_state == 8)  && ((m_age + 1) % SD == 0);
        ctick = (m_state == 10) && ((m_age + 1) % SECD == 0);
        npeak = (stick && vol > m_peak) ? vol : m_peak;

        m_rd[0] = (int'(rd_addr) < m_len[0]) ? mlist[0][rd_addr] : 0;
        a1      = int'(rd_addr) % DEP1;
        m_rd[1] = (a1 < m_len[1]) ? mlist[1][a1] : 0;

        ns = m_state;
        case (m_state)
            0:  ns = 1;
            1:  if (pr) ns = 2; else if (SKIP && pl) ns = 7;
            2:  if (pr) ns = 3;
            3:  if (pr) ns = 4;
            4:  if (pl || pr) ns = 5;
            5:  if (pr) ns = 6;
            6:  if (pr) ns = 7;
            7:  if (lc) ns = 8;
            8:  if (!lc) ns = (npeak >= VMIN) ? 10 : 7;
            10: if (ctick && m_count == 0) ns = 11;
            11: ns = 11;
            default: ns = 0;
        endcase
        if (!en) ns = 0;

        if (stick) begin
            for (int i = DEP0 - 1; i > 0; i--) mlist[0][i] = mlist[0][i-1];
            for (int i = DEP1 - 1; i > 0; i--) mlist[1][i] = mlist[1][i-1];
            mlist[0][0] = vol;
            mlist[1][0] = vol;
            if (m_len[0] < DEP0) m_len[0]++;
            if (m_len[1] < DEP1) m_len[1]++;
            m_peak = npeak;
        end
        if (ns == 7 && m_state != 7) begin
            m_len[0] = 0;
            m_len[1] = 0;
            m_peak   = 0;
        end
        if (ns == 10 && m_state != 10) m_count = CD;
        else if (ctick && m_count > 0) m_count--;
        m_play  = (ns == 11 && m_state != 11);
        m_age   = (ns == m_state) ? m_age + 1 : 0;
        m_state = ns;
        hl = {hl[1:0], btn_l};
        hr = {hr[1:0], btn_r};
        hc = {hc[0], btn_c};
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hl = '0; hr = '0; hc = '0;
            m_state = 0; m_age = 0; m_count = 0; m_peak = 0; m_play = 1'b0;
            m_len[0] = 0; m_len[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        chk("d0_state",    int'(if0.state),    m_state);
        chk("d0_count",    int'(if0.count),    m_count);
        chk("d0_rec_len",  int'(if0.rec_len),  m_len[0]);
        chk("d0_rec_peak", int'(if0.rec_peak), m_peak);
        chk("d0_rd_data",  int'(if0.rd_data),  m_rd[0]);
        chk("d0_play",     int'(if0.play_start), int'(m_play));
        chk("d1_state",    int'(if1.state),    m_state);
        chk("d1_rec_len",  int'(if1.rec_len),  m_len[1]);
        chk("d1_rec_peak", int'(if1.rec_peak), m_peak);
        chk("d1_rd_data",  int'(if1.rd_data),  m_rd[1]);
        chk("d1_play",     int'(if1.play_start), int'(m_play));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_r();
        btn_r = 1'b1; step(3);
        btn_r = 1'b0; step(4);
    endtask

    task automatic walk_to_record();
        en = 1'b1;
        step(1);
        repeat (6) press_r();
    endtask

    // Wait for a target screen on dut0, counting edges; an expired bound is reported as a failure.
    task automatic wait_state(input int target, input int limit, output int n);
        n = 0;
        while (int'(if0.state) != target && n < limit) begin
            step(1);
            n++;
        end
        chk("wait_state_reached", int'(if0.state), target);
    endtask

    initial begin
        int n;
        step(3);
        chk("rst_state",   int'(if0.state), 0);
        chk("rst_rec_len", int'(if0.rec_len), 0);
        chk("rst_rd_data", int'(if0.rd_data), 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_no_en", int'(if0.state), 0);

        en = 1'b1;
        step(1);
        chk("title", int'(if0.state), 1);

        // Held button: one step only.
        btn_r = 1'b1; step(100);
        btn_r = 1'b0; step(4);
        chk("held_r_one_step", int'(if0.state), 2);

        // Left button does nothing in CONTROLS_1.
        btn_l = 1'b1; step(3);
        btn_l = 1'b0; step(4);
        chk("btn_l_ignored", int'(if0.state), 2);

        for (int s = 3; s <= 7; s++) begin
            press_r();
            chk("walk_step", int'(if0.state), s);
        end

        // Quiet take: never reaches VOL_MIN, returns to RECORD_START.
        volume = 5'd2;
        btn_c = 1'b1; step(20);
        btn_c = 1'b0; step(5);
        chk("quiet_back_to_rec_start", int'(if0.state), 7);

        // Good take: 40 held clk at SAMPLE_DIV=4 -> 10 samples.
        volume = 5'd9;
        btn_c = 1'b1; step(40);
        btn_c = 1'b0;
        wait_state(10, 10, n);
        chk("count_loaded",  int'(if0.count), 5);
        chk("d0_len_10",     int'(if0.rec_len), 10);
        chk("d1_len_sat_4",  int'(if1.rec_len), 4);
        chk("peak_9",        int'(if0.rec_peak), 9);

        wait_state(11, 200, n);
        chk("countdown_cycles", n, 48);
        chk("play_start_hi", int'(if0.play_start), 1);
        step(1);
        chk("play_start_lo", int'(if0.play_start), 0);
        chk("play_terminal", int'(if0.state), 11);

        for (int a = 0; a < 4; a++) begin
            rd_addr = 4'(a);
            step(1);
            chk("d1_rd_9", int'(if1.rd_data), 9);
            chk("d0_rd_9", int'(if0.rd_data), 9);
        end
        rd_addr = 4'd10;
        step(1);
        chk("d0_rd_beyond_len", int'(if0.rd_data), 0);

        // en drop from GAME_PLAY keeps the buffer.
        en = 1'b0;
        step(1);
        chk("en_drop_play", int'(if0.state), 0);
        chk("len_retained", int'(if0.rec_len), 10);

        // Ramp recording, then en dropped mid RECORD_SPEAK.
        walk_to_record();
        chk("rewalk_7", int'(if0.state), 7);
        btn_c = 1'b1;
        for (int i = 0; i < 30; i++) begin
            volume = 5'(i / 3 + 1);
            rd_addr = 4'(i % 6);
            step(1);
        end
        chk("in_speak", int'(if0.state), 8);
        en = 1'b0;
        step(1);
        chk("en_drop_speak", int'(if0.state), 0);
        btn_c = 1'b0;
        step(4);

        // Short loud take, then en dropped mid countdown.
        walk_to_record();
        volume = 5'd7;
        btn_c = 1'b1; step(12);
        btn_c = 1'b0;
        wait_state(10, 10, n);
        step(20);
        en = 1'b0;
        step(1);
        chk("en_drop_countdown", int'(if0.state), 0);

        // Asynchronous reset mid-run.
        en = 1'b1;
        step(1);
        press_r();
        press_r();
        chk("pre_reset_state", int'(if0.state), 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_state",   int'(if0.state), 0);
        chk("arst_count",   int'(if0.count), 0);
        chk("arst_rec_len", int'(if0.rec_len), 0);
        chk("arst_peak",    int'(if0.rec_peak), 0);
        chk("arst_rd_data", int'(if0.rd_data), 0);
        chk("arst_d1_len",  int'(if1.rec_len), 0);
        step(2);
        rst_n = 1'b1;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
